bist_signature_checker: RTL and testbench

- Downstream response-analysis stage of the per-scan BIST. It consumes the controller's init/mode/running/finish strobes and the scan-chain outputs.
- Compacts chain outputs into a MISR signature while the controller is shifting. On finish, it compares the signature and the shift count against golden values.
- Presents a latched pass/fail result to the system alongside the controller's bist_end.

---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_misr.sv | 46 ++++
 rtl/bist_signature_checker.sv | 131 +++++++++++++
 tb/tb_bist_signature_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response-analysis stage.
package bist_pkg;

  // Checker state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPACT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COMPACT = ST_COMPACT,
    DONE    = ST_DONE
  } state_e;

  // Default MISR feedback taps (bit i set = feedback into bit i)
  localparam logic [15:0] DEFAULT_POLY = 16'h002D;

  // Shift counter width: must hold EXP_SHIFTS+1 so an overrun is distinguishable
  function automatic int cnt_width(input int exp_shifts);
    return $clog2(exp_shifts + 2);
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, XOR POLY on MSB carry-out,
// XOR in the parallel chain outputs at the low bits.
module bist_misr
  import bist_pkg::*;
#(
  parameter int              WIDTH  = 16,
  parameter int              CHAINS = 1,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [CHAINS-1:0] data_in,
  output logic [WIDTH-1:0]  sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [WIDTH-1:0] data_ext;

  // Next signature: load has priority over a compaction step
  always_comb begin
    data_ext = '0;
    data_ext[CHAINS-1:0] = data_in;
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (enable) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_ext;
    end
  end

  // Signature register, returns to SEED on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_signature_checker.sv
// BIST response analyser: compacts scan outputs during shift, then checks the
// signature and shift count against golden values on finish.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               CHAINS     = 1,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter logic [WIDTH-1:0] GOLDEN     = '0,
  parameter int               EXP_SHIFTS = 26
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            init,
  input  logic                            mode,
  input  logic                            running,
  input  logic                            finish,
  input  logic [CHAINS-1:0]               scan_in,
  output logic [WIDTH-1:0]                signature,
  output logic [$clog2(EXP_SHIFTS+2)-1:0] shift_cnt,
  output logic                            result_valid,
  output logic                            pass,
  output logic                            fail,
  output logic                            seq_error
);

  localparam int CNT_W = cnt_width(EXP_SHIFTS);
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_SHIFTS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              seq_q, seq_d;
  logic              misr_load;
  logic              misr_en;
  logic [WIDTH-1:0]  sig;

  bist_misr #(
    .WIDTH  (WIDTH),
    .CHAINS (CHAINS),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clock   (clock),
    .reset   (reset),
    .load    (misr_load),
    .enable  (misr_en),
    .data_in (scan_in),
    .sig     (sig)
  );

  // Next-state, counter and result logic; init overrides everything, then finish
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    seq_d     = seq_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    if (init) begin
      misr_load = 1'b1;
      cnt_d     = '0;
      valid_d   = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      seq_d     = 1'b0;
      state_d   = COMPACT;
    end else begin
      case (state_q)
        IDLE: begin
          if (finish) begin
            valid_d = 1'b1;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
            seq_d   = 1'b1;
            state_d = DONE;
          end
        end
        COMPACT: begin
          if (finish) begin
            valid_d = 1'b1;
            pass_d  = (sig == GOLDEN) && (cnt_q == EXP_CNT);
            fail_d  = !((sig == GOLDEN) && (cnt_q == EXP_CNT));
            state_d = DONE;
          end else if (mode && running) begin
            misr_en = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Results frozen until init or reset
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      seq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      seq_q   <= seq_d;
    end
  end

  assign signature    = sig;
  assign shift_cnt    = cnt_q;
  assign result_valid = valid_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign seq_error    = seq_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// literal expectations and a randomized session phase.
module tb_bist_signature_checker;

  localparam int         W      = 4;
  localparam logic [3:0] TPOLY  = 4'b0011;
  localparam logic [3:0] TGOLD  = 4'hF;
  localparam int         TEXP   = 4;
  localparam int         CW     = $clog2(TEXP + 2);
  localparam int         CNTMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0, mode = 1'b0, running = 1'b0, finish = 1'b0;
  logic [0:0]    scan_in = 1'b0;
  logic [W-1:0]  signature;
  logic [CW-1:0] shift_cnt;
  logic          result_valid, pass, fail, seq_error;

  int passed = 0;
  int total  = 0;
  bit run_checks = 1'b0;

  // Behavioural model
  int m_sig, m_cnt;
  bit m_valid, m_pass, m_fail, m_seq, m_open;

  bist_signature_checker #(
    .WIDTH(W), .CHAINS(1), .POLY(TPOLY), .SEED(4'h0),
    .GOLDEN(TGOLD), .EXP_SHIFTS(TEXP)
  ) dut (
    .clock(clock), .reset(reset), .init(init), .mode(mode), .running(running),
    .finish(finish), .scan_in(scan_in), .signature(signature), .shift_cnt(shift_cnt),
    .result_valid(result_valid), .pass(pass), .fail(fail), .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int misr_step(input int s, input int d);
    int r;
    r = (s * 2) % 16;
    if (s >= 8) r = r ^ int'(TPOLY);
    return r ^ d;
  endfunction

  // Model: session rules applied on each edge, cleared by reset
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sig <= 0; m_cnt <= 0; m_valid <= 0; m_pass <= 0; m_fail <= 0; m_seq <= 0; m_open <= 0;
    end else if (init) begin
      m_sig <= 0; m_cnt <= 0; m_valid <= 0; m_pass <= 0; m_fail <= 0; m_seq <= 0; m_open <= 1;
    end else if (finish && m_open) begin
      m_valid <= 1;
      m_pass  <= (m_sig == int'(TGOLD)) && (m_cnt == TEXP);
      m_fail  <= !((m_sig == int'(TGOLD)) && (m_cnt == TEXP));
      m_open  <= 0;
    end else if (finish && !m_open && !m_valid) begin
      m_valid <= 1; m_pass <= 0; m_fail <= 1; m_seq <= 1;
    end else if (m_open && mode && running) begin
      m_sig <= misr_step(m_sig, int'(scan_in));
      m_cnt <= (m_cnt >= CNTMAX) ? CNTMAX : m_cnt + 1;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clock) begin
    if (run_checks) begin
      check("sig", int'(signature), m_sig);
      check("cnt", int'(shift_cnt), m_cnt);
      check("valid", int'(result_valid), int'(m_valid));
      check("pass", int'(pass), int'(m_pass));
      check("fail", int'(fail), int'(m_fail));
      check("seq_error", int'(seq_error), int'(m_seq));
      check("invariant", int'((pass && fail) || ((pass || fail) && !result_valid)), 0);
    end
  end

  task automatic cyc(input logic i, input logic f, input logic m, input logic r, input logic s);
    init = i; finish = f; mode = m; running = r; scan_in = s;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic shift(input logic s);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, s);
  endtask

  initial begin
    #1;
    check("rst_sig", int'(signature), 0);
    check("rst_valid", int'(result_valid), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_checks = 1'b1;

    // Sequencing: finish with no session
    cyc(0, 1, 0, 0, 0);
    $display("seq finish: valid=%0d fail=%0d seq=%0d", result_valid, fail, seq_error);
    check("seq_err", int'(seq_error), 1);
    check("seq_fail", int'(fail), 1);
    check("seq_valid", int'(result_valid), 1);
    cyc(1, 0, 0, 0, 0);
    $display("init after seq: valid=%0d seq=%0d sig=%h", result_valid, seq_error, signature);
    check("seq_clr", int'({result_valid, fail, seq_error}), 0);
    check("seq_load", int'(signature), 0);

    // Basic pass: signature 1,3,7,F
    begin
      int exp_sig [4] = '{1, 3, 7, 15};
      for (int k = 0; k < 4; k++) begin
        shift(1);
        $display("shift %0d: sig=%h cnt=%0d", k, signature, shift_cnt);
        check("basic_sig", int'(signature), exp_sig[k]);
      end
    end
    cyc(0, 1, 0, 0, 0);
    $display("basic finish: valid=%0d pass=%0d fail=%0d", result_valid, pass, fail);
    check("basic_pass", int'(pass), 1);
    check("basic_fail", int'(fail), 0);

    // Result hold
    for (int k = 0; k < 10; k++) cyc(0, k == 3, 1, 1, k[0]);
    $display("hold: sig=%h pass=%0d cnt=%0d", signature, pass, shift_cnt);
    check("hold_sig", int'(signature), 15);
    check("hold_pass", int'(pass), 1);
    check("hold_cnt", int'(shift_cnt), 4);

    // Wrong count
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) shift(1);
    $display("overrun: sig=%h cnt=%0d", signature, shift_cnt);
    check("wc_sig", int'(signature), 12);
    check("wc_cnt", int'(shift_cnt), 5);
    cyc(0, 1, 0, 0, 0);
    $display("overrun finish: pass=%0d fail=%0d", pass, fail);
    check("wc_fail", int'(fail), 1);
    check("wc_pass", int'(pass), 0);

    // Hold cycles between shifts 2 and 3
    cyc(1, 0, 0, 0, 0);
    shift(1); shift(1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 1);
      check("gap_sig", int'(signature), 3);
    end
    shift(1); shift(1);
    cyc(0, 1, 0, 0, 0);
    $display("gap finish: sig=%h pass=%0d", signature, pass);
    check("gap_pass", int'(pass), 1);

    // init + finish together: init wins, session open
    cyc(1, 1, 0, 0, 0);
    check("prio_valid", int'(result_valid), 0);
    shift(1);
    check("prio_cnt", int'(shift_cnt), 1);
    $display("priority: valid=%0d cnt=%0d", result_valid, shift_cnt);

    // Async reset mid-shift
    shift(1);
    init = 0; finish = 0; mode = 1; running = 1; scan_in = 1;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    $display("async reset: sig=%h cnt=%0d valid=%0d", signature, shift_cnt, result_valid);
    check("ar_sig", int'(signature), 0);
    check("ar_cnt", int'(shift_cnt), 0);
    check("ar_flags", int'({result_valid, pass, fail, seq_error}), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc(0, 1, 0, 0, 0);
    check("ar_seq", int'(seq_error), 1);

    // Randomized sessions
    for (int k = 0; k < 600; k++) begin
      logic ri, rf, rm, rr, rs;
      ri = ($urandom % 20) == 0;
      rf = ($urandom % 10) == 0;
      rm = ($urandom % 4) != 0;
      rr = ($urandom % 4) != 0;
      rs = 1'($urandom);
      cyc(ri, rf, rm, rr, rs);
      if (ri || rf)
        $display("rand %0d: init=%0d fin=%0d sig=%h cnt=%0d v=%0d p=%0d f=%0d s=%0d",
                 k, ri, rf, signature, shift_cnt, result_valid, pass, fail, seq_error);
    end

    run_checks = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
